// File: rtl/gpio_db_pkg.sv
// rtl/gpio_db_pkg.sv - shared constants and helpers for the GPIO input debouncer
package gpio_db_pkg;

  localparam int GPIO_DB_IO_NUM      = 8;
  localparam int GPIO_DB_SYNC_STAGES = 2;
  localparam int GPIO_DB_CNT_W       = 16;

  // A programmed limit of zero behaves like one: a change is never accepted
  // faster than a single stable cycle after synchronisation.
  function automatic logic [31:0] eff_limit(input logic [31:0] limit);
    return (limit == 32'd0) ? 32'd1 : limit;
  endfunction

endpackage

// File: rtl/gpio_db_chan.sv
// rtl/gpio_db_chan.sv - one channel: synchroniser, stable-time counter, debounced level, edge pulses
module gpio_db_chan
  import gpio_db_pkg::*;
#(
  parameter int   SYNC_STAGES = GPIO_DB_SYNC_STAGES,
  parameter int   CNT_W       = GPIO_DB_CNT_W,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             pad,
  input  logic [CNT_W-1:0] db_limit,
  input  logic             bypass,
  output logic             db,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       lim_m1;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Counter value at which the next differing cycle is accepted; the limit is
  // at most 2^CNT_W-1, so eff_limit-1 always fits the counter width.
  assign lim_m1 = CNT_W'(eff_limit(32'(db_limit)) - 32'd1);

  // Plain shift-register synchroniser, pad enters at bit 0.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Debounce: accept a differing level once it has been stable long enough,
  // pulsing rise/fall in the same cycle the new level becomes visible.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      db   <= RESET_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (bypass || ((sync_lvl != db) && (cnt >= lim_m1))) begin
        db   <= sync_lvl;
        cnt  <= '0;
        rise <= sync_lvl & ~db;
        fall <= ~sync_lvl & db;
      end else if (sync_lvl == db) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - per-channel pad synchroniser and debouncer feeding the GPIO input block
module gpio_in_debounce
  import gpio_db_pkg::*;
#(
  parameter int                IO_NUM      = GPIO_DB_IO_NUM,
  parameter int                SYNC_STAGES = GPIO_DB_SYNC_STAGES,
  parameter int                CNT_W       = GPIO_DB_CNT_W,
  parameter logic [IO_NUM-1:0] RESET_VAL   = '0
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic [IO_NUM-1:0] PAD_IN,
  input  logic [CNT_W-1:0]  DB_LIMIT,
  input  logic [IO_NUM-1:0] BYPASS,
  output logic [IO_NUM-1:0] GPIO_DB,
  output logic [IO_NUM-1:0] RISE,
  output logic [IO_NUM-1:0] FALL
);

  // Channels share only the clock, reset and limit; each is fully independent.
  for (genvar i = 0; i < IO_NUM; i++) begin : g_chan
    gpio_db_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_BIT   (RESET_VAL[i])
    ) u_chan (
      .pclk     (PCLK),
      .presetn  (PRESETN),
      .pad      (PAD_IN[i]),
      .db_limit (DB_LIMIT),
      .bypass   (BYPASS[i]),
      .db       (GPIO_DB[i]),
      .rise     (RISE[i]),
      .fall     (FALL[i])
    );
  end

endmodule
